mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters: DATA_WIDTH, 32, data word width; ADDR_WIDTH, 8, data memory address width; LOCK_MAX, 16, maximum consecutive locked grant cycles (>=2).
REQ-002 The block SHALL have these ports: clk in 1, single clock, all state on rising edge; rst in 1, synchronous active-high reset.
REQ-003 The block SHALL have these requester ports, n=0 (processor) and n=1 (host/loader): reqN in 1, access request; wrN in 1, 1=write 0=read; lockN in 1, hold ownership; addrN in ADDR_WIDTH, address; wdataN in DATA_WIDTH, write data; gntN out 1, access accepted this cycle; rvalidN out 1, read data valid; rdataN out DATA_WIDTH, read data.
REQ-004 The block SHALL have these memory-side ports: mem_wr out 1, write strobe; mem_addr out ADDR_WIDTH, address; mem_data_out out DATA_WIDTH, write data; mem_data_in in DATA_WIDTH, read data, valid one cycle after address.

Function
REQ-005 Grants SHALL be combinational within the cycle: at most one gntN is high per cycle, and gntN is never high without reqN.
REQ-006 In a granted cycle, mem_addr/mem_data_out SHALL equal the granted addrN/wdataN and mem_wr SHALL equal the granted wrN; with no grant, mem_wr=0, mem_addr=0, mem_data_out=0.
REQ-007 The FSM SHALL have states IDLE, OWN0 and OWN1, plus a 1-bit last-grant pointer lg.
REQ-008 In IDLE, a single requester SHALL be granted; if both request, the one with index != lg SHALL be granted; lg is updated to the granted index on every grant.
REQ-009 In IDLE, a grant with lockN=1 SHALL move the FSM to OWNn next cycle; lockN=0 SHALL keep it in IDLE.
REQ-010 In OWNn, only requester n SHALL be granted (when reqN=1); the other requester SHALL wait with gnt=0 regardless of lg.
REQ-011 OWNn SHALL return to IDLE on the cycle after requester n presents lockN=0, or after reqN=0, whichever comes first; the current cycle's access (if reqN=1) is still granted.
REQ-012 A lock counter SHALL count granted cycles in OWNn (including the entry grant); when it reaches LOCK_MAX and the other requester has req=1, the FSM SHALL force IDLE with lg=n, so the other requester wins next cycle; the counter clears in IDLE.
REQ-013 If the other requester is idle at LOCK_MAX, the owner SHALL keep ownership and the counter SHALL saturate at LOCK_MAX.
REQ-014 A granted read SHALL produce rvalidN=1 exactly one cycle later, with rdataN=mem_data_in in that cycle; rdataN SHALL be 0 when rvalidN=0.
REQ-015 Writes SHALL NOT produce rvalid; back-to-back reads SHALL produce back-to-back rvalid with no bubble.
REQ-016 Read-after-write to the same address by consecutive grants SHALL be passed straight to memory in order; no forwarding is done by the block.
REQ-017 Changes to reqN/addrN/wrN without a grant SHALL have no effect on the memory or internal state.

Reset
REQ-018 While rst=1 at a clock edge: FSM=IDLE, lg=1 (requester 0 wins the first tie), lock counter=0, rvalid0=rvalid1=0; gnt0, gnt1 and mem_wr SHALL be 0 during any cycle with rst=1.
REQ-019 A read granted in the cycle before reset asserts SHALL NOT produce rvalid after reset; a lock held across reset SHALL be released.

Verification
REQ-020 Reset then req0=1 wr0=0 addr0=0x05 for one cycle, mem holds 0x1234 at 0x05 -> gnt0=1, mem_wr=0, next cycle rvalid0=1, rdata0=0x1234.
REQ-021 req0=req1=1, both writes, held 4 cycles -> grants 0,1,0,1; mem_wr=1 every cycle; lg ends at 1.
REQ-022 req1=1 lock1=1 for 30 cycles, req0=1 from cycle 3 -> gnt1 for 16 cycles, gnt0 on cycle 17, then requester 1 regains ownership per REQ-008/009.
REQ-023 req1 lock1=1 for 3 cycles, then lock1=0 with req1=1 on cycle 4, req0 waiting -> gnt1 cycles 1-4, gnt0 cycle 5.
REQ-024 req0 read granted, rst=1 next cycle -> rvalid0=0, gnt0=gnt1=0, mem_wr=0; after release, tie grants requester 0.
REQ-025 Random req/wr/lock on both ports for 10k cycles against a reference model -> no dual grant, no lost or extra rvalid, no wait longer than LOCK_MAX+1 cycles, memory contents match.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: processor (0) and host/loader (1) share one memory port.
// Fair alternation on ties, optional bus locking bounded by LOCK_MAX, one-cycle read return.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0,
  input  logic                  wr0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,

  input  logic                  req1,
  input  logic                  wr1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,

  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             lg_q, lg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_pend0_q, rd_pend0_d;
  logic             rd_pend1_q, rd_pend1_d;

  logic             gnt0_c, gnt1_c;
  logic             own_idx, own_req, own_lock, oth_req;
  logic [CNT_W-1:0] cnt_inc;

  // Grant decision: combinational, suppressed entirely while in reset
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            gnt0_c = lg_q;
            gnt1_c = ~lg_q;
          end else begin
            gnt0_c = req0;
            gnt1_c = req1;
          end
        end
        OWN0:    gnt0_c = req0;
        OWN1:    gnt1_c = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    own_idx  = (state_q == OWN1);
    own_req  = own_idx ? req1  : req0;
    own_lock = own_idx ? lock1 : lock0;
    oth_req  = own_idx ? req0  : req1;
    cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  end

  // Ownership FSM and lock counter
  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt0_c) begin
          lg_d = 1'b0;
          if (lock0) begin
            state_d = OWN0;
            cnt_d   = CNT_ONE;
          end
        end else if (gnt1_c) begin
          lg_d = 1'b1;
          if (lock1) begin
            state_d = OWN1;
            cnt_d   = CNT_ONE;
          end
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          lg_d = own_idx;
          if (!own_lock) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            // Owner has had its full share and the other side is waiting: hand over.
            if (cnt_inc == CNT_MAX && oth_req) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rd_pend0_d = gnt0_c & ~wr0;
    rd_pend1_d = gnt1_c & ~wr1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lg_q       <= 1'b1;
      cnt_q      <= '0;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lg_q       <= lg_d;
      cnt_q      <= cnt_d;
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
    end
  end

  // Memory-side mux: zeros when idle so the bus is quiet without a grant
  always_comb begin
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    if (gnt0_c) begin
      mem_wr       = wr0;
      mem_addr     = addr0;
      mem_data_out = wdata0;
    end else if (gnt1_c) begin
      mem_wr       = wr1;
      mem_addr     = addr1;
      mem_data_out = wdata1;
    end
  end

  // Read return stage: a read pending across a reset edge is dropped
  always_comb begin
    gnt0    = gnt0_c;
    gnt1    = gnt1_c;
    rvalid0 = rd_pend0_q & ~rst;
    rvalid1 = rd_pend1_q & ~rst;
    rdata0  = rvalid0 ? mem_data_in : '0;
    rdata1  = rvalid1 ? mem_data_in : '0;
  end

endmodule
